// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register.
// Captures the EX result, HI/LO write, and load/store fields for the MEM stage.
// It also carries the multi-cycle (MADD/MSUB) partial product and step count
// back to EX across bubbles.
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   stall[5:0], flush        pipeline control (only stall[3], stall[4] used)
//   ex_*                     EX-stage results to be registered
//   hilo_i, cnt_i            EX multi-cycle partial product and step count
//   mem_*                    registered copies presented to MEM
//   hilo_o, cnt_o            registered partial product and count returned to EX
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic [7:0]  mem_aluop,
  output logic [31:0] mem_mem_addr,
  output logic [31:0] mem_reg2,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
);

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned OP_W       = 8;
  localparam int unsigned HILO_W     = 64;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned STALL_EX   = 3;
  localparam int unsigned STALL_MEM  = 4;

  // Payload moved from EX to MEM as one unit.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     wdata;
    logic                  whilo;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
    logic [OP_W-1:0]       aluop;
    logic [DATA_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     reg2;
  } stage_t;

  // Per-edge action, highest priority first: flush, bubble, advance, hold.
  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_ADVANCE = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_FLUSH   = 2'd3
  } act_e;

  stage_t              ex_c;
  stage_t              stage_q;
  stage_t              stage_d;
  logic [HILO_W-1:0]   hilo_q;
  logic [HILO_W-1:0]   hilo_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  act_e                act_c;
  logic                unused_stall_c;

  // Stall bits outside the EX/MEM pair are intentionally ignored.
  assign unused_stall_c = ^{stall[5], stall[2:0]};

  // Gather EX inputs into one payload.
  always_comb begin
    ex_c          = '0;
    ex_c.wd       = ex_wd;
    ex_c.wreg     = ex_wreg;
    ex_c.wdata    = ex_wdata;
    ex_c.whilo    = ex_whilo;
    ex_c.hi       = ex_hi;
    ex_c.lo       = ex_lo;
    ex_c.aluop    = ex_aluop;
    ex_c.mem_addr = ex_mem_addr;
    ex_c.reg2     = ex_reg2;
  end

  // Decode the edge action. stall[3]=0 with stall[4]=1 falls into advance.
  always_comb begin
    act_c = ACT_HOLD;
    if (flush) begin
      act_c = ACT_FLUSH;
    end else if (stall[STALL_EX] && !stall[STALL_MEM]) begin
      act_c = ACT_BUBBLE;
    end else if (!stall[STALL_EX]) begin
      act_c = ACT_ADVANCE;
    end
  end

  // Next-state values for the payload and the multi-cycle accumulator.
  always_comb begin
    stage_d = stage_q;
    hilo_d  = hilo_q;
    cnt_d   = cnt_q;
    case (act_c)
      ACT_FLUSH: begin
        stage_d = '0;
        hilo_d  = '0;
        cnt_d   = '0;
      end
      ACT_BUBBLE: begin
        // EX is still iterating: kill the MEM slot but keep the partial result.
        stage_d = '0;
        hilo_d  = hilo_i;
        cnt_d   = cnt_i;
      end
      ACT_ADVANCE: begin
        stage_d = ex_c;
        hilo_d  = '0;
        cnt_d   = '0;
      end
      default: begin
        stage_d = stage_q;
        hilo_d  = hilo_q;
        cnt_d   = cnt_q;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
      hilo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_wd       = stage_q.wd;
  assign mem_wreg     = stage_q.wreg;
  assign mem_wdata    = stage_q.wdata;
  assign mem_whilo    = stage_q.whilo;
  assign mem_hi       = stage_q.hi;
  assign mem_lo       = stage_q.lo;
  assign mem_aluop    = stage_q.aluop;
  assign mem_mem_addr = stage_q.mem_addr;
  assign mem_reg2     = stage_q.reg2;
  assign hilo_o       = hilo_q;
  assign cnt_o        = cnt_q;

endmodule
